// File: rtl/pc_redirect_unit_if.sv
// rtl/pc_redirect_unit_if.sv - pipeline-side bundle for the fetch PC unit
interface pc_redirect_unit_if #(
  parameter int CNT_W = 32
);
  logic             run_en;
  logic             stall_if;
  logic             branch;
  logic             is_btype_ex;
  logic             jal_ex;
  logic             jalr_ex;
  logic [31:0]      br_target;
  logic [31:0]      jalr_target;
  logic             halt_ex;
  logic [31:0]      pc_if;
  logic [31:0]      pc_plus4;
  logic             flush_id;
  logic             flush_ex;
  logic             halted;
  logic [CNT_W-1:0] br_cnt;
  logic [CNT_W-1:0] br_taken_cnt;

  // pipeline / debug side drives the EX decisions and observes fetch state
  modport master (
    output run_en, stall_if, branch, is_btype_ex, jal_ex, jalr_ex,
           br_target, jalr_target, halt_ex,
    input  pc_if, pc_plus4, flush_id, flush_ex, halted, br_cnt, br_taken_cnt
  );

  modport slave (
    input  run_en, stall_if, branch, is_btype_ex, jal_ex, jalr_ex,
           br_target, jalr_target, halt_ex,
    output pc_if, pc_plus4, flush_id, flush_ex, halted, br_cnt, br_taken_cnt
  );
endinterface

// File: rtl/pc_redirect_unit.sv
// rtl/pc_redirect_unit.sv - IF-stage PC register with EX redirects, halt state and branch counters
module pc_redirect_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int          CNT_W    = 32
) (
  input  logic          clk,
  input  logic          rstn,
  pc_redirect_unit_if.slave bus
);

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_RUN   = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [31:0]      pc, pc_nxt;
  logic [31:0]      target;
  logic             active;
  logic             redirect;
  logic             halt_go;
  logic [CNT_W-1:0] br_cnt, br_taken_cnt;

  assign active   = bus.run_en && (state == ST_RUN);
  assign halt_go  = active && bus.halt_ex;
  assign redirect = active && !bus.halt_ex &&
                    (bus.branch || bus.jal_ex || bus.jalr_ex);

  // JALR clears bit 0 of the computed address; branch/JAL targets pass through
  assign target = bus.jalr_ex ? (bus.jalr_target & ~32'd1) : bus.br_target;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= ST_RESET;
      pc    <= RESET_PC;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    case (state)
      ST_RESET: state_nxt = ST_RUN;
      ST_RUN: begin
        if (bus.run_en) begin
          if (bus.halt_ex) begin
            state_nxt = ST_HALT;
          end else if (redirect) begin
            pc_nxt = target;
          end else if (!bus.stall_if) begin
            pc_nxt = pc + 32'd4;
          end
        end
      end
      ST_HALT: state_nxt = ST_HALT;
      default: state_nxt = ST_RESET;
    endcase
  end

  // statistics only see branches that actually resolve while running
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      br_cnt       <= '0;
      br_taken_cnt <= '0;
    end else if (active && bus.is_btype_ex) begin
      br_cnt <= br_cnt + CNT_W'(1);
      if (bus.branch) begin
        br_taken_cnt <= br_taken_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.pc_if        = pc;
  assign bus.pc_plus4     = pc + 32'd4;
  assign bus.flush_id     = redirect || halt_go;
  assign bus.flush_ex     = redirect || halt_go;
  assign bus.halted       = (state == ST_HALT);
  assign bus.br_cnt       = br_cnt;
  assign bus.br_taken_cnt = br_taken_cnt;

endmodule

// File: tb/tb_pc_redirect_unit.sv
// tb/tb_pc_redirect_unit.sv - directed self-checking bench for pc_redirect_unit
module tb_pc_redirect_unit;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  // narrow counters keep the wrap-around case short
  pc_redirect_unit_if #(.CNT_W(4)) bus ();

  pc_redirect_unit #(
    .RESET_PC(32'h0000_3000),
    .CNT_W   (4)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    bus.run_en      = 1'b1;
    bus.stall_if    = 1'b0;
    bus.branch      = 1'b0;
    bus.is_btype_ex = 1'b0;
    bus.jal_ex      = 1'b0;
    bus.jalr_ex     = 1'b0;
    bus.br_target   = 32'h0;
    bus.jalr_target = 32'h0;
    bus.halt_ex     = 1'b0;
  endtask

  task automatic check_flush(input string tag, input logic exp);
    #1;
    check_eq({tag, "_flush_id"}, 32'(bus.flush_id), 32'(exp));
    check_eq({tag, "_flush_ex"}, 32'(bus.flush_ex), 32'(exp));
  endtask

  task automatic check_cnt(input string tag, input logic [3:0] exp_br, input logic [3:0] exp_tk);
    check_eq({tag, "_br_cnt"}, 32'(bus.br_cnt), 32'(exp_br));
    check_eq({tag, "_br_taken_cnt"}, 32'(bus.br_taken_cnt), 32'(exp_tk));
  endtask

  // release away from the edge; the next edge moves RESET to RUN
  task automatic release_reset();
    @(negedge clk);
    rstn = 1'b1;
    tick();
  endtask

  initial begin
    clear_in();
    bus.branch      = 1'b1;
    bus.is_btype_ex = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check_eq("rst_pc_if", bus.pc_if, 32'h3000);
    check_eq("rst_pc_plus4", bus.pc_plus4, 32'h3004);
    check_eq("rst_halted", 32'(bus.halted), 32'h0);
    check_cnt("rst", 4'd0, 4'd0);
    check_flush("rst", 1'b0);
    clear_in();

    release_reset();
    for (int i = 0; i < 4; i++) begin
      check_eq("seq_pc_if", bus.pc_if, 32'h3000 + 32'(4 * i));
      check_eq("seq_flush_id", 32'(bus.flush_id), 32'h0);
      tick();
    end
    check_eq("seq_pc_3010", bus.pc_if, 32'h3010);

    bus.is_btype_ex = 1'b1;
    bus.branch      = 1'b1;
    bus.br_target   = 32'h3100;
    check_flush("br", 1'b1);
    tick();
    clear_in();
    check_eq("br_pc_if", bus.pc_if, 32'h3100);
    check_cnt("br", 4'd1, 4'd1);

    bus.jalr_ex     = 1'b1;
    bus.jalr_target = 32'h2001;
    bus.stall_if    = 1'b1;
    check_flush("jalr", 1'b1);
    tick();
    clear_in();
    check_eq("jalr_pc_if", bus.pc_if, 32'h2000);
    check_cnt("jalr", 4'd1, 4'd1);

    bus.jal_ex    = 1'b1;
    bus.br_target = 32'h3020;
    check_flush("jal", 1'b1);
    tick();
    clear_in();
    check_eq("jal_pc_if", bus.pc_if, 32'h3020);

    bus.stall_if    = 1'b1;
    bus.is_btype_ex = 1'b1;
    check_flush("stall", 1'b0);
    tick();
    bus.is_btype_ex = 1'b0;
    check_eq("stall1_pc_if", bus.pc_if, 32'h3020);
    check_cnt("stall_nt", 4'd2, 4'd1);
    tick();
    check_eq("stall2_pc_if", bus.pc_if, 32'h3020);
    tick();
    bus.stall_if = 1'b0;
    check_eq("stall3_pc_if", bus.pc_if, 32'h3020);
    tick();
    check_eq("resume_pc_if", bus.pc_if, 32'h3024);

    bus.jal_ex    = 1'b1;
    bus.br_target = 32'h3040;
    tick();
    clear_in();
    check_eq("pre_halt_pc_if", bus.pc_if, 32'h3040);
    bus.halt_ex = 1'b1;
    check_flush("halt", 1'b1);
    tick();
    clear_in();
    check_eq("halt_halted", 32'(bus.halted), 32'h1);
    check_eq("halt_pc_if", bus.pc_if, 32'h3040);
    bus.branch      = 1'b1;
    bus.is_btype_ex = 1'b1;
    bus.br_target   = 32'h3100;
    check_flush("halted_br", 1'b0);
    tick();
    check_eq("halted_pc_if", bus.pc_if, 32'h3040);
    check_eq("halted_still", 32'(bus.halted), 32'h1);
    check_cnt("halted", 4'd2, 4'd1);
    clear_in();
    #2;
    rstn = 1'b0;
    #1;
    check_eq("midrst_pc_if", bus.pc_if, 32'h3000);
    check_eq("midrst_halted", 32'(bus.halted), 32'h0);
    check_cnt("midrst", 4'd0, 4'd0);

    release_reset();
    bus.is_btype_ex = 1'b1;
    repeat (15) tick();
    check_cnt("preload", 4'hF, 4'h0);
    check_eq("preload_pc_if", bus.pc_if, 32'h303C);
    bus.branch    = 1'b1;
    bus.br_target = 32'h3200;
    tick();
    clear_in();
    check_cnt("wrap", 4'h0, 4'h1);
    check_eq("wrap_pc_if", bus.pc_if, 32'h3200);

    bus.run_en      = 1'b0;
    bus.branch      = 1'b1;
    bus.is_btype_ex = 1'b1;
    bus.halt_ex     = 1'b1;
    bus.br_target   = 32'h3300;
    check_flush("runen0", 1'b0);
    tick();
    check_eq("runen0_pc_if", bus.pc_if, 32'h3200);
    check_eq("runen0_halted", 32'(bus.halted), 32'h0);
    check_cnt("runen0", 4'h0, 4'h1);
    clear_in();

    bus.jal_ex    = 1'b1;
    bus.br_target = 32'hFFFF_FFFC;
    tick();
    clear_in();
    check_eq("top_pc_if", bus.pc_if, 32'hFFFF_FFFC);
    check_eq("top_pc_plus4", bus.pc_plus4, 32'h0);
    tick();
    check_eq("wrap_pc0", bus.pc_if, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_redirect_unit.md
# pc_redirect_unit

Instruction-fetch PC unit for the 5-stage RV32I pipeline. It holds the PC register and picks the next fetch address from sequential flow, EX-stage redirects and hazard stalls. Redirects are taken branches (the `branch` decision from the EX-stage branch control), JAL and JALR. The unit also produces the IF/ID and ID/EX flush pulses, a RUN/HALT state for ECALL and EBREAK, and branch statistics counters for the debug unit.

## Interface
Parameters:
- RESET_PC, 32'h0000_3000, fetch address after reset
- CNT_W, 32, width of the statistics counters

Ports:
- clk  input  1  system clock, rising edge
- rstn  input  1  asynchronous reset, active-low
- run_en  input  1  debug-unit run enable; 0 freezes PC, state and counters
- stall_if  input  1  load-use stall from the hazard unit; holds PC
- branch  input  1  EX-stage B-type taken decision
- is_btype_ex  input  1  EX holds a valid B-type instruction
- jal_ex  input  1  EX holds JAL
- jalr_ex  input  1  EX holds JALR
- br_target  input  32  PC_ex+imm, used for a taken branch and for JAL
- jalr_target  input  32  rs1+imm, used for JALR
- halt_ex  input  1  EX holds ECALL or EBREAK
- pc_if  output  32  current fetch address
- pc_plus4  output  32  pc_if+4
- flush_id  output  1  clear IF/ID at the next edge
- flush_ex  output  1  clear ID/EX at the next edge
- halted  output  1  state is HALT
- br_cnt  output  CNT_W  number of B-type instructions resolved in EX
- br_taken_cnt  output  CNT_W  number of taken B-type instructions

## Operation
States:
- RESET: only during rstn=0.
- RUN: entered on the first edge after reset release.
- HALT: entered from RUN on halt_ex and run_en. Left only via rstn.

Redirect:
- redirect = run_en & RUN & !halt_ex & (branch | jal_ex | jalr_ex).
- Target priority: jalr_ex, then jal_ex/branch.
- JALR target is {jalr_target[31:1],1'b0}.
- br_target is used unmodified. No misalignment check.

Next-PC priority at each edge (only when run_en=1 and state=RUN):
1. halt_ex: hold PC, go to HALT.
2. redirect: PC <= target.
3. stall_if: hold PC.
4. Otherwise: PC <= pc_if+4, wrapping mod 2^32.

Flush outputs:
- flush_id = flush_ex = redirect | (halt_ex & run_en & RUN).
- Both are combinational, and both are 0 in HALT.
- stall_if asserted together with a redirect or halt is ignored.

Counters:
- br_cnt increments when is_btype_ex & run_en & RUN.
- br_taken_cnt increments when, in addition, branch=1.
- Both wrap to 0 past all-ones.
- branch=1 without is_btype_ex redirects the PC but is not counted.

run_en=0:
- PC, state and counters hold.
- flush_id and flush_ex are 0.

Reset values (immediate and asynchronous on rstn=0, including mid-redirect or mid-halt):
- pc_if = RESET_PC
- pc_plus4 = RESET_PC+4
- halted = 0
- br_cnt = 0, br_taken_cnt = 0
- flush_id = 0, flush_ex = 0

## Timing
- pc_if comes from a register. pc_plus4 is combinational from pc_if.
- Redirect latency:
  - Inputs are valid in cycle t; flushes are high in cycle t.
  - pc_if = target in cycle t+1.
  - The two wrong-path instructions (in IF and ID at cycle t) are killed at the t→t+1 edge.
- Halt:
  - halt_ex is high in cycle t; flushes are high in cycle t.
  - halted = 1 and pc_if is frozen from cycle t+1.
  - Later branch, jal_ex, jalr_ex, stall_if and halt_ex inputs are ignored until reset.
- Stall: PC holds for every cycle stall_if=1. Sequential flow resumes the cycle after it drops.
- Counters update on the same edge as the PC. New values are visible in cycle t+1.
- Reset is asserted asynchronously and released synchronously to the first clk edge with rstn=1. The first fetch is RESET_PC.

## Test plan
- Reset, then 4 free-running cycles → pc_if = 3000, 3004, 3008, 300C. flush_id and flush_ex stay 0.
- At pc_if=3010: is_btype_ex=1, branch=1, br_target=3100 → flush_id = flush_ex = 1 in that cycle. Next cycle: pc_if=3100, br_cnt=1, br_taken_cnt=1.
- jalr_ex=1 with jalr_target=2001, with stall_if=1 in the same cycle → pc_if=2000 next cycle, flushes asserted, stall ignored.
- stall_if=1 for 3 cycles at pc_if=3020 → pc_if holds at 3020, then 3024. Not-taken B-type during the stall → br_cnt increments, br_taken_cnt unchanged.
- halt_ex=1 at pc_if=3040, then branch=1 with br_target=3100 → halted=1 and pc_if=3040 frozen. Next, rstn pulsed low mid-cycle → pc_if=3000 and halted=0 immediately.
- Preload via 2^32-1 counted branches (or a forced counter), then one more B-type → br_cnt wraps to 0. run_en=0 with branch=1 → no PC change, no flush, no count.
